ysyx_22050078_ifu_fetch: RTL
============================

YSYX_22050078_IFU_FETCH -- requirements
Module: ysyx_22050078_ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000: PC loaded at reset.
REQ-002 SHALL have parameter NOP_INS, default 32'h13 (ADDI x0,x0,0): instruction presented when the output holds no valid fetch.
REQ-003 One clock; reset is synchronous and active-low (i_clk, i_rst_n).
REQ-004 Ports:
  i_clk  in  1  clock, rising edge
  i_rst_n  in  1  synchronous active-low reset
  i_stall  in  1  downstream hold; IF/ID write disabled this cycle
  i_redirect  in  1  branch/jump taken; flush and refetch
  i_redirect_pc  in  CPU_WIDTH  redirect target
  o_imem_req_valid  out  1  fetch request valid
  i_imem_req_ready  in  1  memory accepts request
  o_imem_addr  out  CPU_WIDTH  fetch address
  i_imem_rsp_valid  in  1  fetch data valid
  i_imem_rsp_data  in  INS_WIDTH  fetched instruction
  o_ifu_ins  out  INS_WIDTH  instruction to IF/ID
  o_ifu_pc  out  CPU_WIDTH  PC of o_ifu_ins
  o_ifu_valid  out  1  output buffer holds an unconsumed instruction
  o_ifu_bubble  out  1  IF/ID bubble request (= ~o_ifu_valid | i_redirect)

Function
REQ-005 States: REQ (request pending), WAIT (one request outstanding), DROP (outstanding response to discard); at most one outstanding request.
REQ-006 o_imem_req_valid = (state==REQ) & ~i_redirect & (~o_ifu_valid | ~i_stall); o_imem_addr = pc.
REQ-007 REQ -> WAIT on o_imem_req_valid & i_imem_req_ready; pc <= pc + 4 in the same cycle.
REQ-008 WAIT, i_imem_rsp_valid & ~i_redirect: buffer <= {rsp_data, pc_of_request}, o_ifu_valid <= 1, -> REQ.
REQ-009 A buffered instruction is consumed in any cycle with o_ifu_valid & ~i_stall; o_ifu_valid clears unless a new response is captured in that same cycle.
REQ-010 While i_stall=1, o_ifu_ins/o_ifu_pc/o_ifu_valid SHALL hold unchanged; no new request issues while the buffer is occupied.
REQ-011 i_redirect has highest priority: pc <= {i_redirect_pc[CPU_WIDTH-1:2], 2'b00}; o_ifu_valid <= 0; REQ -> REQ; WAIT -> DROP; DROP -> DROP.
REQ-012 i_redirect coincident with i_imem_rsp_valid in WAIT: response discarded, -> REQ (not DROP).
REQ-013 DROP: i_imem_rsp_valid discards data, -> REQ; buffer untouched.
REQ-014 When o_ifu_valid=0, o_ifu_ins = NOP_INS and o_ifu_pc = 0.
REQ-015 PC arithmetic is modulo 2^CPU_WIDTH; wrap at all-ones is silent.
REQ-016 Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency (no fetch pipelining).

Reset
REQ-017 On i_rst_n=0 at a rising edge: pc=RESET_PC, state=REQ, o_ifu_valid=0, o_ifu_ins=NOP_INS, o_ifu_pc=0; o_imem_req_valid=0 during the reset cycle.
REQ-018 Reset in WAIT/DROP abandons the outstanding request; a late response after reset SHALL be ignored until a new request issues.

Structure
REQ-019 CPU_WIDTH, INS_WIDTH, reset PC and NOP encoding come from the shared defines.v; state encoding is a local constant.
REQ-020 PC and output buffer SHALL use the existing stl_reg sub-module; no other sub-module.

Verification
REQ-021 Reset release, req_ready=1, rsp 1 cycle later = 0x00000513 -> addr 0x80000000, o_ifu_valid=1, o_ifu_pc=0x80000000, next addr 0x80000004.
REQ-022 i_stall=1 for 3 cycles with valid buffer -> outputs stable, o_imem_req_valid=0; release -> consumed, next request issues same cycle.
REQ-023 i_redirect to 0x80000100 while WAIT, response next cycle -> response dropped, o_ifu_bubble=1, next addr 0x80000100.
REQ-024 i_redirect coincident with rsp_valid -> no capture, next addr = target, no DROP visit.
REQ-025 i_redirect_pc = 0x80000102 -> fetch addr 0x80000100.
REQ-026 Reset asserted in WAIT, stale rsp_valid after release -> ignored, first fetch at 0x80000000.

Source files
------------

// File: rtl/ysyx_22050078_ifu_fetch_pkg.sv
// Shared widths, default reset/NOP encodings and fetch FSM state type for the IFU.
package ysyx_22050078_ifu_fetch_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [INS_WIDTH-1:0] NOP_INS_DEF  = 32'h0000_0013;
  localparam logic [CPU_WIDTH-1:0] PC_STEP      = CPU_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Instructions are word aligned; the low two bits of any target are forced to zero.
  function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] addr);
    return addr & ~CPU_WIDTH'(3);
  endfunction

endpackage

// File: rtl/ysyx_22050078_ifu_fetch_stl_reg.sv
// Generic register with write enable and synchronous active-low reset to a fixed value.
module ysyx_22050078_ifu_fetch_stl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Load on write enable; reset has priority and is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_22050078_ifu_fetch.sv
// Instruction fetch unit: single-outstanding fetch requests, one-entry output buffer
// towards IF/ID, redirect flush with discard of in-flight responses.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   REQ   | ready to issue a fetch request at pc
//   WAIT  | one request outstanding, its response will be captured
//   DROP  | one request outstanding, its response will be discarded
module ysyx_22050078_ifu_fetch
  import ysyx_22050078_ifu_fetch_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INS_WIDTH-1:0] NOP_INS  = NOP_INS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_rsp_valid,
  input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
  output logic [INS_WIDTH-1:0] o_ifu_ins,
  output logic [CPU_WIDTH-1:0] o_ifu_pc,
  output logic                 o_ifu_valid,
  output logic                 o_ifu_bubble
);

  localparam int BUF_W = INS_WIDTH + CPU_WIDTH + 1;
  localparam logic [BUF_W-1:0] BUF_EMPTY = {NOP_INS, {CPU_WIDTH{1'b0}}, 1'b0};

  fetch_state_e state, state_nxt;

  logic [CPU_WIDTH-1:0] pc, pc_nxt;
  logic                 pc_wen;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic                 buf_wen;
  logic                 req_fire, capture, consume;

  // Reset gating keeps the request low during the reset cycle whatever state is held.
  assign o_imem_req_valid = i_rst_n & (state == ST_REQ) & ~i_redirect
                          & (~o_ifu_valid | ~i_stall);
  assign o_imem_addr      = pc;
  assign req_fire         = o_imem_req_valid & i_imem_req_ready;
  assign capture          = (state == ST_WAIT) & i_imem_rsp_valid & ~i_redirect;
  assign consume          = o_ifu_valid & ~i_stall;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redirect dominates every other event.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ: begin
        if (!i_redirect && req_fire) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_redirect) begin
          // A response arriving with the redirect is the outstanding one: nothing left to drop.
          state_nxt = i_imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (i_imem_rsp_valid) begin
          state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        // Same reasoning: a coincident response retires the outstanding request.
        if (i_imem_rsp_valid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  // PC update: redirect target (aligned) or sequential advance on an accepted request.
  always_comb begin
    pc_nxt = pc;
    pc_wen = 1'b0;
    if (i_redirect) begin
      pc_nxt = align_pc(i_redirect_pc);
      pc_wen = 1'b1;
    end else if (req_fire) begin
      pc_nxt = pc + PC_STEP;
      pc_wen = 1'b1;
    end
  end

  ysyx_22050078_ifu_fetch_stl_reg #(
    .WIDTH     (CPU_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .wen   (pc_wen),
    .din   (pc_nxt),
    .dout  (pc)
  );

  // Output buffer update. In WAIT pc is already one step past the outstanding request,
  // so the request address is recovered as pc - 4. An empty buffer holds NOP/0 directly.
  always_comb begin
    buf_d   = BUF_EMPTY;
    buf_wen = 1'b0;
    if (i_redirect) begin
      buf_wen = 1'b1;
    end else if (capture) begin
      buf_d   = {i_imem_rsp_data, pc - PC_STEP, 1'b1};
      buf_wen = 1'b1;
    end else if (consume) begin
      buf_wen = 1'b1;
    end
  end

  ysyx_22050078_ifu_fetch_stl_reg #(
    .WIDTH     (BUF_W),
    .RESET_VAL (BUF_EMPTY)
  ) u_buf_reg (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .wen   (buf_wen),
    .din   (buf_d),
    .dout  (buf_q)
  );

  assign {o_ifu_ins, o_ifu_pc, o_ifu_valid} = buf_q;
  assign o_ifu_bubble = ~o_ifu_valid | i_redirect;

endmodule
